// File: rtl/rat_io_pkg.sv
// Shared types and default port-ID map for the RAT MCU I/O hub.
package rat_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } irq_state_t;

  localparam logic [7:0] LEDS     = 8'h40;
  localparam logic [7:0] SWITCHES = 8'h20;
  localparam logic [7:0] STAT     = 8'hF0;
  localparam logic [7:0] MASK     = 8'hF1;

endpackage

// File: rtl/rat_io_hub_if.sv
// MCU-side port bus of the RAT I/O hub: address, write data/strobe, read data, interrupt.
interface rat_io_hub_if;

  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_PORT;
  logic       INTERRUPT;

  modport master (
    output PORT_ID, OUT_PORT, IO_STRB,
    input  IN_PORT, INTERRUPT
  );

  modport slave (
    input  PORT_ID, OUT_PORT, IO_STRB,
    output IN_PORT, INTERRUPT
  );

endinterface

// File: rtl/irq_edge_sync.sv
// One interrupt source: two-flop synchronizer plus history flop for rising-edge detect.
module irq_edge_sync (
  input  logic CLK,
  input  logic RESET_N,
  input  logic src,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic hist;

  // Reset to 1 so a line already high when reset releases is not seen as an edge
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise = sync2 & ~hist;

endmodule

// File: rtl/rat_io_hub.sv
// Port-mapped output registers, input channel mux and maskable edge interrupts for the RAT MCU.
module rat_io_hub
  import rat_io_pkg::*;
#(
  parameter int         N_OUT       = 4,
  parameter int         N_IN        = 4,
  parameter int         N_IRQ       = 4,
  parameter logic [7:0] OUT_BASE    = LEDS,
  parameter logic [7:0] IN_BASE     = SWITCHES,
  parameter logic [7:0] IRQ_STAT_ID = STAT,
  parameter logic [7:0] IRQ_MASK_ID = MASK,
  parameter int         PULSE_LEN   = 2
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  rat_io_hub_if.slave          bus,
  input  logic [8*N_IN-1:0]    IN_DATA,
  input  logic [N_IRQ-1:0]     IRQ_SRC,
  output logic [8*N_OUT-1:0]   OUT_DATA
);

  if (N_OUT < 1 || N_OUT > 8) begin : g_bad_n_out
    $error("rat_io_hub: N_OUT must be 1..8");
  end
  if (N_IN < 1 || N_IN > 8) begin : g_bad_n_in
    $error("rat_io_hub: N_IN must be 1..8");
  end
  if (N_IRQ < 1 || N_IRQ > 8) begin : g_bad_n_irq
    $error("rat_io_hub: N_IRQ must be 1..8");
  end
  if (PULSE_LEN < 1 || PULSE_LEN > 15) begin : g_bad_pulse
    $error("rat_io_hub: PULSE_LEN must be 1..15");
  end
  if (int'(OUT_BASE) + N_OUT - 1 > 255) begin : g_bad_out_base
    $error("rat_io_hub: output bank runs past port 255");
  end
  if (int'(IN_BASE) + N_IN - 1 > 255) begin : g_bad_in_base
    $error("rat_io_hub: input bank runs past port 255");
  end

  logic [7:0]         out_idx;
  logic [7:0]         in_idx;
  logic               is_stat;
  logic               is_mask;
  logic               out_hit;
  logic               in_hit;
  logic               wr_stat;
  logic               wr_mask;
  logic               wr_out;
  logic [7:0]         rd_data;
  logic [7:0]         pending_ext;
  logic [7:0]         mask_ext;
  logic [7:0]         in_port_q;
  logic [8*N_OUT-1:0] out_q;
  logic [N_IRQ-1:0]   rise;
  logic [N_IRQ-1:0]   pending;
  logic [N_IRQ-1:0]   mask;
  logic [N_IRQ-1:0]   clr;
  logic               active;
  irq_state_t         state;
  irq_state_t         state_next;
  logic [3:0]         cnt;
  logic [3:0]         cnt_next;
  logic               irq_q;

  // Status and mask IDs win over the banks so an overlapping map still behaves predictably
  assign out_idx = bus.PORT_ID - OUT_BASE;
  assign in_idx  = bus.PORT_ID - IN_BASE;
  assign is_stat = (bus.PORT_ID == IRQ_STAT_ID);
  assign is_mask = (bus.PORT_ID == IRQ_MASK_ID);
  assign out_hit = (bus.PORT_ID >= OUT_BASE) && (out_idx < 8'(N_OUT));
  assign in_hit  = (bus.PORT_ID >= IN_BASE) && (in_idx < 8'(N_IN));

  assign wr_stat = bus.IO_STRB & is_stat;
  assign wr_mask = bus.IO_STRB & is_mask & ~is_stat;
  assign wr_out  = bus.IO_STRB & out_hit & ~is_stat & ~is_mask;

  always_comb begin
    pending_ext              = '0;
    mask_ext                 = '0;
    pending_ext[N_IRQ-1:0]   = pending;
    mask_ext[N_IRQ-1:0]      = mask;
    rd_data                  = 8'h00;
    if (is_stat) begin
      rd_data = pending_ext;
    end else if (is_mask) begin
      rd_data = mask_ext;
    end else if (in_hit) begin
      for (int k = 0; k < N_IN; k++) begin
        if (in_idx == 8'(k)) begin
          rd_data = IN_DATA[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      in_port_q <= 8'h00;
      out_q     <= '0;
    end else begin
      in_port_q <= rd_data;
      for (int k = 0; k < N_OUT; k++) begin
        if (wr_out && out_idx == 8'(k)) begin
          out_q[8*k +: 8] <= bus.OUT_PORT;
        end
      end
    end
  end

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    irq_edge_sync u_sync (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .src     (IRQ_SRC[i]),
      .rise    (rise[i])
    );
  end

  // Write-one-to-clear; a fresh edge in the same cycle keeps the bit set
  assign clr = wr_stat ? bus.OUT_PORT[N_IRQ-1:0] : '0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
      if (wr_mask) begin
        mask <= bus.OUT_PORT[N_IRQ-1:0];
      end
    end
  end

  assign active = |(pending & mask);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      cnt   <= '0;
      irq_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      irq_q <= (state_next == FIRE);
    end
  end

  // WAIT blocks re-pulsing until every enabled pending bit has been cleared or masked
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (active) begin
          state_next = FIRE;
          cnt_next   = 4'(PULSE_LEN - 1);
        end
      end
      FIRE: begin
        if (cnt == 4'd0) begin
          state_next = WAIT;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      WAIT: begin
        if (!active) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign bus.IN_PORT   = in_port_q;
  assign bus.INTERRUPT = irq_q;
  assign OUT_DATA      = out_q;

endmodule

// File: tb/tb_rat_io_hub.sv
// Randomised and directed checks of the RAT I/O hub against a register-level reference model.
module tb_rat_io_hub;

  localparam int N_OUT     = 4;
  localparam int N_IN      = 4;
  localparam int N_IRQ     = 4;
  localparam int PULSE_LEN = 2;

  logic               CLK = 1'b0;
  logic               RESET_N = 1'b0;
  logic [8*N_IN-1:0]  IN_DATA;
  logic [N_IRQ-1:0]   IRQ_SRC;
  logic [8*N_OUT-1:0] OUT_DATA;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] out_model [N_OUT];
  logic [7:0] mask_model;

  rat_io_hub_if bus ();

  rat_io_hub #(
    .N_OUT       (N_OUT),
    .N_IN        (N_IN),
    .N_IRQ       (N_IRQ),
    .OUT_BASE    (8'h40),
    .IN_BASE     (8'h20),
    .IRQ_STAT_ID (8'hF0),
    .IRQ_MASK_ID (8'hF1),
    .PULSE_LEN   (PULSE_LEN)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .bus      (bus),
    .IN_DATA  (IN_DATA),
    .IRQ_SRC  (IRQ_SRC),
    .OUT_DATA (OUT_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [8*N_OUT-1:0] packed_outs();
    logic [8*N_OUT-1:0] v;
    for (int k = 0; k < N_OUT; k++) v[8*k +: 8] = out_model[k];
    return v;
  endfunction

  // Port-map rules of the hub expressed directly as an address lookup
  function automatic logic [7:0] ref_read(input logic [7:0] id, input logic [7:0] pend,
                                          input logic [7:0] msk, input logic [8*N_IN-1:0] ind);
    int off;
    if (id == 8'hF0) return pend;
    if (id == 8'hF1) return msk;
    off = int'(id) - 32'h20;
    if (off >= 0 && off < N_IN) return ind[8*off +: 8];
    return 8'h00;
  endfunction

  task automatic ref_write(input logic [7:0] id, input logic [7:0] data);
    int off;
    off = int'(id) - 32'h40;
    if (id == 8'hF1) mask_model = data & 8'((1 << N_IRQ) - 1);
    else if (off >= 0 && off < N_OUT) out_model[off] = data;
  endtask

  task automatic write_port(input logic [7:0] id, input logic [7:0] data);
    bus.PORT_ID  = id;
    bus.OUT_PORT = data;
    bus.IO_STRB  = 1'b1;
    tick();
    bus.IO_STRB  = 1'b0;
    bus.PORT_ID  = 8'h7F;
    ref_write(id, data);
  endtask

  task automatic read_port(input logic [7:0] id, output logic [7:0] val);
    bus.PORT_ID = id;
    bus.IO_STRB = 1'b0;
    tick();
    val = bus.IN_PORT;
  endtask

  task automatic wait_irq(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.INTERRUPT === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_pulse(output int n);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.INTERRUPT === 1'b1) n++;
      else break;
    end
  endtask

  task automatic watch_high(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.INTERRUPT !== 1'b0) n++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    int hi;
    bus.PORT_ID = 8'h00; bus.OUT_PORT = 8'h00; bus.IO_STRB = 1'b0;
    IN_DATA = '0; IRQ_SRC = 4'hF; RESET_N = 1'b0;
    for (int k = 0; k < N_OUT; k++) out_model[k] = 8'h00;
    mask_model = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (OUT_DATA !== '0 || bus.IN_PORT !== 8'h00 || bus.INTERRUPT !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: OUT_DATA=%h IN_PORT=%h INTERRUPT=%b, want 0/00/0",
               OUT_DATA, bus.IN_PORT, bus.INTERRUPT);
    end
    #3 RESET_N = 1'b1;
    watch_high(6, hi);
    checks++;
    if (hi != 0) begin
      errors++;
      $display("[TB] FAIL reset_no_edge: interrupt high %0d cycles, want 0", hi);
    end
    read_port(8'hF0, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_pending: got %h, want 00", v);
    end
    read_port(8'hF1, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_mask: got %h, want 00", v);
    end
  endtask

  task automatic test_write();
    write_port(8'h42, 8'hA5);
    checks++;
    if (OUT_DATA !== 32'h00A5_0000) begin
      errors++;
      $display("[TB] FAIL write_42: OUT_DATA=%h, want 00a50000", OUT_DATA);
    end
  endtask

  task automatic test_read();
    logic [7:0] v;
    IN_DATA = '0;
    IN_DATA[15:8] = 8'h3C;
    read_port(8'h21, v);
    checks++;
    if (v !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL read_ch1: got %h, want 3c", v);
    end
    read_port(8'h7F, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("[TB] FAIL read_unmapped: got %h, want 00", v);
    end
  endtask

  task automatic test_random_bus();
    logic [7:0] id;
    logic [7:0] d;
    logic [7:0] v;
    logic [7:0] exp_v;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: id = 8'h40 + 8'($urandom_range(0, 5));
        1: id = 8'hF1;
        2: begin
          id = 8'($urandom);
          if (id == 8'hF0 || id == 8'hF1) id = 8'h7F;
        end
        default: id = 8'h20 + 8'($urandom_range(0, 3));
      endcase
      d = 8'($urandom);
      write_port(id, d);
      checks++;
      if (OUT_DATA !== packed_outs()) begin
        errors++;
        $display("[TB] FAIL rand_write id=%h: OUT_DATA=%h, want %h", id, OUT_DATA, packed_outs());
      end
      case ($urandom_range(0, 2))
        0: id = 8'h20 + 8'($urandom_range(0, 5));
        1: id = ($urandom_range(0, 1) == 0) ? 8'hF0 : 8'hF1;
        default: id = 8'($urandom);
      endcase
      IN_DATA = {$urandom};
      exp_v = ref_read(id, 8'h00, mask_model, IN_DATA);
      read_port(id, v);
      checks++;
      if (v !== exp_v) begin
        errors++;
        $display("[TB] FAIL rand_read id=%h: got %h, want %h", id, v, exp_v);
      end
    end
    write_port(8'hF1, 8'h00);
  endtask

  task automatic test_irq_pulse();
    bit seen;
    int n;
    logic [7:0] v;
    write_port(8'hF1, 8'h01);
    IRQ_SRC[0] = 1'b0;
    repeat (4) tick();
    IRQ_SRC[0] = 1'b1;
    wait_irq(12, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL irq_fire: interrupt seen=%0d, want 1", seen);
    end
    count_pulse(n);
    checks++;
    if (n != PULSE_LEN) begin
      errors++;
      $display("[TB] FAIL irq_width: got %0d cycles, want %0d", n, PULSE_LEN);
    end
    read_port(8'hF0, v);
    checks++;
    if (v !== 8'h01) begin
      errors++;
      $display("[TB] FAIL irq_pending: got %h, want 01", v);
    end
    write_port(8'hF0, 8'h01);
    watch_high(6, n);
    read_port(8'hF0, v);
    checks++;
    if (n != 0 || v !== 8'h00) begin
      errors++;
      $display("[TB] FAIL irq_clear: high=%0d pending=%h, want 0/00", n, v);
    end
  endtask

  task automatic test_masked();
    int n;
    logic [7:0] v;
    write_port(8'hF1, 8'h00);
    IRQ_SRC[1] = 1'b0;
    repeat (4) tick();
    IRQ_SRC[1] = 1'b1;
    watch_high(8, n);
    read_port(8'hF0, v);
    checks++;
    if (n != 0 || v !== 8'h02) begin
      errors++;
      $display("[TB] FAIL masked_hold: high=%0d pending=%h, want 0/02", n, v);
    end
    write_port(8'hF1, 8'h02);
    tick();
    checks++;
    if (bus.INTERRUPT !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unmask_fire: INTERRUPT=%b, want 1", bus.INTERRUPT);
    end
    count_pulse(n);
    checks++;
    if (n != PULSE_LEN) begin
      errors++;
      $display("[TB] FAIL unmask_width: got %0d, want %0d", n, PULSE_LEN);
    end
    write_port(8'hF0, 8'h02);
    write_port(8'hF1, 8'h00);
  endtask

  task automatic test_collision();
    logic [7:0] v;
    IRQ_SRC[0] = 1'b0;
    repeat (4) tick();
    IRQ_SRC[0] = 1'b1;
    tick();
    tick();
    // The third edge after the line changes is where the synchronised edge lands
    write_port(8'hF0, 8'h01);
    read_port(8'hF0, v);
    checks++;
    if (v !== 8'h01) begin
      errors++;
      $display("[TB] FAIL collision_set_wins: pending=%h, want 01", v);
    end
    write_port(8'hF0, 8'h01);
    read_port(8'hF0, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("[TB] FAIL collision_w1c: pending=%h, want 00", v);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int n;
    logic [7:0] v;
    IRQ_SRC = '0;
    repeat (4) tick();
    write_port(8'hF1, 8'h03);
    IRQ_SRC[0] = 1'b1;
    wait_irq(12, seen);
    IRQ_SRC[1] = 1'b1;
    count_pulse(n);
    checks++;
    if (!seen || n != PULSE_LEN) begin
      errors++;
      $display("[TB] FAIL b2b_first: seen=%0d width=%0d, want 1/%0d", seen, n, PULSE_LEN);
    end
    watch_high(6, n);
    read_port(8'hF0, v);
    checks++;
    if (n != 0 || v !== 8'h03) begin
      errors++;
      $display("[TB] FAIL b2b_no_repulse: high=%0d pending=%h, want 0/03", n, v);
    end
    write_port(8'hF0, 8'h01);
    watch_high(5, n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("[TB] FAIL b2b_wait_hold: high=%0d, want 0", n);
    end
    write_port(8'hF1, 8'h00);
    watch_high(3, n);
    write_port(8'hF1, 8'h02);
    tick();
    checks++;
    if (n != 0 || bus.INTERRUPT !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_mask_to_idle: high=%0d INTERRUPT=%b, want 0/1", n, bus.INTERRUPT);
    end
    count_pulse(n);
    write_port(8'hF0, 8'h0F);
    write_port(8'hF1, 8'h00);
  endtask

  task automatic test_random_irq();
    logic [N_IRQ-1:0] m;
    logic [N_IRQ-1:0] r;
    int n;
    int exp_n;
    logic [7:0] v;
    for (int round = 0; round < 8; round++) begin
      m = N_IRQ'($urandom);
      r = N_IRQ'($urandom);
      IRQ_SRC = '0;
      repeat (4) tick();
      write_port(8'hF0, 8'h0F);
      write_port(8'hF1, 8'(m));
      repeat (2) tick();
      IRQ_SRC = r;
      exp_n = ((r & m) != 0) ? PULSE_LEN : 0;
      watch_high(14, n);
      checks++;
      if (n != exp_n) begin
        errors++;
        $display("[TB] FAIL rand_irq m=%h r=%h: high=%0d, want %0d", m, r, n, exp_n);
      end
      read_port(8'hF0, v);
      checks++;
      if (v !== 8'(r)) begin
        errors++;
        $display("[TB] FAIL rand_irq_pending m=%h r=%h: got %h, want %h", m, r, v, 8'(r));
      end
      write_port(8'hF0, 8'h0F);
      write_port(8'hF1, 8'h00);
      repeat (2) tick();
    end
  endtask

  task automatic test_reset_mid_fire();
    bit seen;
    int n;
    logic [7:0] v;
    IRQ_SRC = 4'hE;
    repeat (4) tick();
    write_port(8'hF1, 8'h01);
    IRQ_SRC = 4'hF;
    wait_irq(12, seen);
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if (!seen || bus.INTERRUPT !== 1'b0 || OUT_DATA !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_fire: seen=%0d INTERRUPT=%b OUT_DATA=%h, want 1/0/0",
               seen, bus.INTERRUPT, OUT_DATA);
    end
    for (int k = 0; k < N_OUT; k++) out_model[k] = 8'h00;
    mask_model = 8'h00;
    repeat (2) @(posedge CLK);
    #3 RESET_N = 1'b1;
    watch_high(10, n);
    read_port(8'hF0, v);
    checks++;
    if (n != 0 || v !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_release: high=%0d pending=%h, want 0/00", n, v);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_random_bus();
    test_irq_pulse();
    test_masked();
    test_collision();
    test_back_to_back();
    test_random_irq();
    test_reset_mid_fire();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
